// File: rtl/axi4_ram_responder.sv
// AXI4 responder backed by a single-clock dual-port RAM. The write and read channels are
// independent FSMs that share the RAM, so the DSP delay-line masters can run without a memory controller.
module axi4_ram_responder #(
    parameter int                      ADDR_WIDTH_P = 32,
    parameter int                      DATA_WIDTH_P = 32,
    parameter int                      ID_WIDTH_P   = 4,
    parameter int                      MEM_DEPTH_P  = 4096,
    parameter logic [ADDR_WIDTH_P-1:0] BASE_ADDR_P  = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // AW channel
    input  logic [ID_WIDTH_P-1:0]     awid,
    input  logic [ADDR_WIDTH_P-1:0]   awaddr,
    input  logic [7:0]                awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic                      awvalid,
    output logic                      awready,
    // W channel
    input  logic [DATA_WIDTH_P-1:0]   wdata,
    input  logic [DATA_WIDTH_P/8-1:0] wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    // B channel
    output logic [ID_WIDTH_P-1:0]     bid,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    // AR channel
    input  logic [ID_WIDTH_P-1:0]     arid,
    input  logic [ADDR_WIDTH_P-1:0]   araddr,
    input  logic [7:0]                arlen,
    input  logic [2:0]                arsize,
    input  logic [1:0]                arburst,
    input  logic                      arvalid,
    output logic                      arready,
    // R channel
    output logic [ID_WIDTH_P-1:0]     rid,
    output logic [DATA_WIDTH_P-1:0]   rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready,
    // FSM state visibility
    output logic [1:0]                w_state_dbg,
    output logic [1:0]                r_state_dbg
);

    // Handshake rule on every channel: a transfer happens on a rising clk edge where both
    // valid and ready are high; a source holds valid and its payload stable until then.

    localparam int BYTES = DATA_WIDTH_P / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH_P);

    localparam logic [ADDR_WIDTH_P:0] BASE_X  = {1'b0, BASE_ADDR_P};
    localparam logic [ADDR_WIDTH_P:0] LIMIT_X = BASE_X + (ADDR_WIDTH_P+1)'(MEM_DEPTH_P * BYTES);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_t;

    function automatic logic in_range(input logic [ADDR_WIDTH_P-1:0] a);
        return ({1'b0, a} >= BASE_X) && ({1'b0, a} < LIMIT_X);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH_P-1:0] a);
        logic [ADDR_WIDTH_P-1:0] off;
        off = a - BASE_ADDR_P;
        return off[OFFS +: IDX_W];
    endfunction

    // WRAP bursts step like INCR; FIXED bursts reuse the same address.
    function automatic logic [ADDR_WIDTH_P-1:0] next_addr(input logic [ADDR_WIDTH_P-1:0] a,
                                                          input logic [2:0] size,
                                                          input logic [1:0] burst);
        if (burst == BURST_FIXED) return a;
        return a + (ADDR_WIDTH_P'(1) << size);
    endfunction

    logic [DATA_WIDTH_P-1:0] mem [MEM_DEPTH_P];
    logic [DATA_WIDTH_P-1:0] rd_q;

    w_state_t                w_state;
    logic [ID_WIDTH_P-1:0]   aw_id;
    logic [ADDR_WIDTH_P-1:0] aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic [7:0]              w_cnt;
    logic                    w_err;

    r_state_t                r_state;
    logic [ID_WIDTH_P-1:0]   ar_id;
    logic [ADDR_WIDTH_P-1:0] ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic [7:0]              r_cnt;

    logic                    w_beat;
    logic                    w_in_range;
    logic                    w_last_beat;
    logic                    mem_we;
    logic                    rd_en;

    assign w_beat      = (w_state == W_DATA) && wvalid && wready;
    assign w_in_range  = in_range(aw_addr);
    assign w_last_beat = (w_cnt == aw_len);
    assign mem_we      = w_beat && w_in_range;
    assign rd_en       = (r_state == R_FETCH);

    // Non-blocking update gives read-first behaviour when both ports hit one word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb[i]) mem[word_idx(aw_addr)][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) rd_q <= mem[word_idx(ar_addr)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state  <= W_IDLE;
            awready  <= 1'b1;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            bid      <= '0;
            aw_id    <= '0;
            aw_addr  <= '0;
            aw_len   <= '0;
            aw_size  <= '0;
            aw_burst <= '0;
            w_cnt    <= '0;
            w_err    <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        aw_id    <= awid;
                        aw_addr  <= awaddr;
                        aw_len   <= awlen;
                        aw_size  <= awsize;
                        aw_burst <= awburst;
                        w_cnt    <= '0;
                        w_err    <= 1'b0;
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        aw_addr <= next_addr(aw_addr, aw_size, aw_burst);
                        w_cnt   <= w_cnt + 8'd1;
                        w_err   <= w_err || !w_in_range;
                        // Either wlast or the length count closes the burst; disagreement is an error.
                        if (wlast || w_last_beat) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= aw_id;
                            bresp   <= (w_err || !w_in_range || (wlast != w_last_beat))
                                       ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_err   <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                    awready <= 1'b1;
                    wready  <= 1'b0;
                    bvalid  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= R_IDLE;
            arready  <= 1'b1;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rresp    <= RESP_OKAY;
            rid      <= '0;
            ar_id    <= '0;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
            ar_burst <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        ar_id    <= arid;
                        ar_addr  <= araddr;
                        ar_len   <= arlen;
                        ar_size  <= arsize;
                        ar_burst <= arburst;
                        r_cnt    <= '0;
                        arready  <= 1'b0;
                        r_state  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rvalid  <= 1'b1;
                    rid     <= ar_id;
                    rresp   <= in_range(ar_addr) ? RESP_OKAY : RESP_SLVERR;
                    rlast   <= (r_cnt == ar_len);
                    r_state <= R_DATA;
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (rlast) begin
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            ar_addr <= next_addr(ar_addr, ar_size, ar_burst);
                            r_cnt   <= r_cnt + 8'd1;
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                    arready <= 1'b1;
                    rvalid  <= 1'b0;
                    rlast   <= 1'b0;
                end
            endcase
        end
    end

    // rd_q only reloads in R_FETCH, so rdata holds steady through an rready stall.
    assign rdata = (rvalid && rresp == RESP_OKAY) ? rd_q : '0;

    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;

endmodule

// File: tb/tb_axi4_ram_responder.sv
// Directed bench for axi4_ram_responder: write/read bursts, back-pressure on B and R,
// out-of-range accesses, byte strobes, FIXED bursts and reset in the middle of a read burst.
module tb_axi4_ram_responder;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [1:0]  w_state_dbg;
    logic [1:0]  r_state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    axi4_ram_responder dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic do_write(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst, input logic [3:0] strb,
                            input logic [31:0] base, input int b_hold, input logic [1:0] exp_resp);
        int t;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < TMO) begin @(negedge clk); t++; end
        check_b({tag, "_awready"}, awready, 1'b1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = base + 32'(b); wstrb = strb; wlast = (b == int'(len)); wvalid = 1'b1;
            t = 0;
            while (!wready && t < TMO) begin @(negedge clk); t++; end
            check_b({tag, "_wready"}, wready, 1'b1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        for (int i = 0; i < b_hold; i++) begin
            check_b({tag, "_bvalid_hold"}, bvalid, 1'b1);
            check_b({tag, "_awready_hold"}, awready, 1'b0);
            @(negedge clk);
        end
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < TMO) begin @(negedge clk); t++; end
        check_b({tag, "_bvalid"}, bvalid, 1'b1);
        check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        check({tag, "_bid"}, 32'(bid), 32'(id));
        @(negedge clk);
        bready = 1'b0;
        check_b({tag, "_bvalid_clr"}, bvalid, 1'b0);
        check_b({tag, "_awready_back"}, awready, 1'b1);
    endtask

    // Expected data on beat b is exp_base + b; rst_beat >= 0 pulses reset when that beat is valid.
    task automatic do_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [31:0] exp_base,
                           input logic [1:0] exp_resp, input int stall_beat, input int rst_beat);
        int t;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        t = 0;
        while (!arready && t < TMO) begin @(negedge clk); t++; end
        check_b({tag, "_arready"}, arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (!rvalid && t < TMO) begin @(negedge clk); t++; end
            check_b({tag, "_rvalid"}, rvalid, 1'b1);
            if (b == rst_beat) begin
                rst_n = 1'b0;
                #1;
                check_b({tag, "_rst_rvalid"}, rvalid, 1'b0);
                check_b({tag, "_rst_arready"}, arready, 1'b1);
                check_b({tag, "_rst_rlast"}, rlast, 1'b0);
                check({tag, "_rst_rdata"}, rdata, 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            check({tag, "_rdata"}, rdata, exp_base + 32'(b));
            check({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
            check_b({tag, "_rlast"}, rlast, b == int'(len));
            check({tag, "_rid"}, 32'(rid), 32'(id));
            if (b == stall_beat) begin
                repeat (5) begin
                    @(negedge clk);
                    check_b({tag, "_stall_rvalid"}, rvalid, 1'b1);
                    check({tag, "_stall_rdata"}, rdata, exp_base + 32'(b));
                    check_b({tag, "_stall_rlast"}, rlast, b == int'(len));
                end
            end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
        check_b({tag, "_rvalid_end"}, rvalid, 1'b0);
        check_b({tag, "_arready_end"}, arready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(negedge clk);

        check_b("rst_awready", awready, 1'b1);
        check_b("rst_arready", arready, 1'b1);
        check_b("rst_wready", wready, 1'b0);
        check_b("rst_bvalid", bvalid, 1'b0);
        check_b("rst_rvalid", rvalid, 1'b0);
        check_b("rst_rlast", rlast, 1'b0);
        check("rst_bresp", 32'(bresp), 32'h0);
        check("rst_rresp", 32'(rresp), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bid", 32'(bid), 32'h0);
        check("rst_rid", 32'(rid), 32'h0);
        check("rst_wstate", 32'(w_state_dbg), 32'h0);
        check("rst_rstate", 32'(r_state_dbg), 32'h0);
        rst_n = 1'b1;

        // Single beat write then read back.
        do_write("t1_w", 4'h3, 32'h40, 8'd0, 2'b01, 4'hF, 32'hDEADBEEF, 0, 2'b00);
        do_read("t1_r", 4'h5, 32'h40, 8'd0, 32'hDEADBEEF, 2'b00, -1, -1);

        // Four-beat INCR burst, with an rready stall on beat 2 of the read.
        do_write("t2_w", 4'h7, 32'h100, 8'd3, 2'b01, 4'hF, 32'h1, 0, 2'b00);
        do_read("t2_r", 4'h9, 32'h100, 8'd3, 32'h1, 2'b00, 1, -1);

        // B back-pressure for 10 cycles.
        do_write("t4_w", 4'hA, 32'h180, 8'd0, 2'b01, 4'hF, 32'h77, 10, 2'b00);
        do_read("t4_r", 4'hA, 32'h180, 8'd0, 32'h77, 2'b00, -1, -1);

        // First byte past the RAM: SLVERR, word 0 must not be aliased.
        do_write("t5_w0", 4'h1, 32'h0, 8'd0, 2'b01, 4'hF, 32'hCAFEF00D, 0, 2'b00);
        do_write("t5_woor", 4'h2, 32'h4000, 8'd0, 2'b01, 4'hF, 32'h12345678, 0, 2'b10);
        do_read("t5_roor", 4'h2, 32'h4000, 8'd0, 32'h0, 2'b10, -1, -1);
        do_read("t5_r0", 4'h1, 32'h0, 8'd0, 32'hCAFEF00D, 2'b00, -1, -1);

        // Partial strobes merge into existing data.
        do_write("t6_wf", 4'h4, 32'h300, 8'd0, 2'b01, 4'hF, 32'hFFFFFFFF, 0, 2'b00);
        do_write("t6_ws", 4'h4, 32'h300, 8'd0, 2'b01, 4'h3, 32'hAAAA5555, 0, 2'b00);
        do_read("t6_r", 4'h4, 32'h300, 8'd0, 32'hFFFF5555, 2'b00, -1, -1);

        // FIXED burst: both beats land on the same word, the second wins.
        do_write("fx_w", 4'h6, 32'h400, 8'd1, 2'b00, 4'hF, 32'h50, 0, 2'b00);
        do_read("fx_r", 4'h6, 32'h400, 8'd0, 32'h51, 2'b00, -1, -1);

        // Reset during beat 2 of an 8-beat read, then a clean re-read.
        do_write("t7_w", 4'h8, 32'h200, 8'd7, 2'b01, 4'hF, 32'h10, 0, 2'b00);
        do_read("t7_rst", 4'h8, 32'h200, 8'd7, 32'h10, 2'b00, -1, 1);
        do_read("t7_r", 4'hB, 32'h200, 8'd7, 32'h10, 2'b00, -1, -1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected summary before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
